// File: rtl/apb_cmd_master.sv
// APB initiator: buffers read/write commands in a small FIFO and issues them as
// SETUP/ACCESS transfers, returning one response (data, slave error or timeout) per command.
module apb_cmd_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWRDATA,
  input  logic [DATA_W-1:0] PRDDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_wdata [FIFO_DEPTH];
  logic              fifo_write [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [CNT_W-1:0]  tcnt;
  logic              full, empty, push, pop;
  logic              timed_out, access_done;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign cmd_ready   = !full;
  assign push        = cmd_valid && !full;
  assign timed_out   = (TIMEOUT != 0) && !PREADY && (tcnt == CNT_LAST);
  assign access_done = PREADY || timed_out;
  assign pop         = !empty && ((state == IDLE) || ((state == ACCESS) && access_done));
  assign busy        = !empty || (state != IDLE);

  // Storage needs no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
      fifo_write[wr_ptr] <= cmd_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // A command leaving ACCESS with the FIFO non-empty goes straight to SETUP, keeping PSEL high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWRDATA     <= '0;
      tcnt        <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      if (pop) begin
        PADDR   <= fifo_addr[rd_ptr];
        PWRITE  <= fifo_write[rd_ptr];
        PWRDATA <= fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            state   <= SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          tcnt    <= '0;
        end
        ACCESS: begin
          if (access_done) begin
            rsp_valid <= 1'b1;
            if (PREADY) begin
              rsp_err   <= PSLVERR;
              rsp_rdata <= (!PSLVERR && !PWRITE) ? PRDDATA : '0;
            end else begin
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
            PENABLE <= 1'b0;
            if (pop) begin
              state <= SETUP;
            end else begin
              state <= IDLE;
              PSEL  <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: address-driven APB slave model plus
// scoreboard queues of expected SETUP contents and responses.
module tb_apb_cmd_master;

  localparam int TMO = 8;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWRDATA, PRDDATA;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_t;

  rsp_t rsp_q[$];
  apb_t apb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_len = 0;
  int   slv_cnt = 0;
  apb_t cur;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWRDATA(PWRDATA), .PRDDATA(PRDDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave behaviour is a pure function of the address: wait states, error and read data.
  function automatic int wait_for(input logic [31:0] a);
    if (a == 32'h10) return 3;
    if (a[11:8] == 4'hF) return 1000;
    return int'(a[11:8]);
  endfunction

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    if (a == 32'h10) return 32'h0000_00A7;
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic logic err_for(input logic [31:0] a);
    return a[15:12] == 4'hE;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (PSEL && PENABLE && rst_n) begin
      PREADY  = (slv_cnt >= wait_for(PADDR));
      PSLVERR = PREADY && err_for(PADDR);
      PRDDATA = rdata_for(PADDR);
      slv_cnt++;
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDDATA = 32'h0;
      slv_cnt = 0;
    end
  end

  // Response first: a back-to-back SETUP can share the negedge with the previous response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checkOutput("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          checkOutput("rsp_rdata", rsp_rdata, e.rdata);
          checkOutput("rsp_err", rsp_err, e.err);
          checkOutput("rsp_timeout", rsp_timeout, e.tout);
          checkOutput("access_len", acc_len, e.acc);
        end
      end
      if (PSEL && !PENABLE) begin
        acc_len = 0;
        if (apb_q.size() == 0) begin
          checkOutput("setup_unexpected", PSEL, 1'b0);
        end else begin
          cur = apb_q.pop_front();
          checkOutput("setup_paddr", PADDR, cur.addr);
          checkOutput("setup_pwrite", PWRITE, cur.write);
          checkOutput("setup_pwdata", PWRDATA, cur.wdata);
        end
      end
      if (PSEL && PENABLE) begin
        acc_len++;
        checkOutput("access_paddr_hold", PADDR, cur.addr);
        checkOutput("access_pwdata_hold", PWRDATA, cur.wdata);
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    rsp_t r;
    apb_t p;
    int   n = 0;
    bit   done = 0;
    r.tout  = (wait_for(a) >= TMO);
    r.acc   = r.tout ? TMO : wait_for(a) + 1;
    r.err   = r.tout || err_for(a);
    r.rdata = (!w && !r.err) ? rdata_for(a) : 32'h0;
    p.addr  = a;
    p.write = w;
    p.wdata = w ? d : 32'h0;
    rsp_q.push_back(r);
    apb_q.push_back(p);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!done && n < 200) begin
      done = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!done) begin
      checkOutput("push_accepted", done, 1'b1);
      void'(rsp_q.pop_back());
      void'(apb_q.pop_back());
    end
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while ((rsp_q.size() != 0 || busy) && n < bound) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    checkOutput("drain_left", 32'(rsp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int got;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    #12;
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst_psel", PSEL, 1'b0);
    checkOutput("rst_penable", PENABLE, 1'b0);
    checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_paddr", PADDR, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] write 0x4 <- 0x5, zero wait");
    applyStimulus(1'b1, 32'h4, 32'h5);
    checkOutput("lat_n0_psel", PSEL, 1'b0);
    checkOutput("lat_n0_busy", busy, 1'b1);
    @(posedge clk); #1;
    checkOutput("lat_n1_psel", PSEL, 1'b1);
    checkOutput("lat_n1_penable", PENABLE, 1'b0);
    checkOutput("lat_n1_pwrite", PWRITE, 1'b1);
    checkOutput("lat_n1_pwdata", PWRDATA, 32'h5);
    @(posedge clk); #1;
    checkOutput("lat_n2_penable", PENABLE, 1'b1);
    checkOutput("lat_n2_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    checkOutput("lat_n3_rsp_valid", rsp_valid, 1'b1);
    checkOutput("lat_n3_rsp_err", rsp_err, 1'b0);
    @(posedge clk); #1;
    checkOutput("lat_n4_rsp_valid", rsp_valid, 1'b0);
    checkOutput("lat_n4_psel", PSEL, 1'b0);
    checkOutput("idle_paddr_hold", PADDR, 32'h4);
    waitIdle(50);

    $display("[TB] read 0x10 with 3 wait states, then slave error read");
    applyStimulus(1'b0, 32'h10, 32'hDEAD_BEEF);
    waitIdle(50);
    applyStimulus(1'b0, 32'hE020, 32'h0);
    waitIdle(50);

    $display("[TB] mixed commands");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = {16'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 2)), 8'($urandom)};
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
    end
    waitIdle(300);

    $display("[TB] timeout, boundary wait of 7, exact timeout");
    applyStimulus(1'b0, 32'h0F00, 32'h0);
    applyStimulus(1'b1, 32'h0700, 32'h77);
    applyStimulus(1'b0, 32'h0800, 32'h0);
    applyStimulus(1'b0, 32'h0024, 32'h0);
    waitIdle(300);

    $display("[TB] burst fills the FIFO");
    applyStimulus(1'b1, 32'h0500, 32'h11);
    applyStimulus(1'b0, 32'h0030, 32'h0);
    applyStimulus(1'b1, 32'h0034, 32'h33);
    applyStimulus(1'b0, 32'h0038, 32'h0);
    applyStimulus(1'b1, 32'h003C, 32'h55);
    checkOutput("burst_full_ready", cmd_ready, 1'b0);
    got = 0;
    for (int n = 0; n < 100 && got < 5; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) got++;
      if (got < 5) checkOutput("burst_psel", PSEL, 1'b1);
    end
    checkOutput("burst_rsp_count", got, 5);
    waitIdle(50);

    $display("[TB] reset during ACCESS with two queued");
    applyStimulus(1'b0, 32'h0F04, 32'h0);
    applyStimulus(1'b0, 32'h0F08, 32'h0);
    applyStimulus(1'b0, 32'h0F0C, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst_pre_penable", PENABLE, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_psel", PSEL, 1'b0);
    checkOutput("rst_mid_penable", PENABLE, 1'b0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_cmd_ready", cmd_ready, 1'b1);
    rsp_q.delete();
    apb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_rsp_valid", rsp_valid, 1'b0);
      checkOutput("post_rst_psel", PSEL, 1'b0);
    end
    applyStimulus(1'b1, 32'h0020, 32'h1234);
    waitIdle(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
